cordic_vectoring: RTL and testbench
===================================

Name: cordic_vectoring

Overview:
- Iterative CORDIC in vectoring mode: the inverse of the rotation-mode sine/window generator.
- Takes a signed Cartesian pair (X, Y) and returns the phase atan2(Y, X) and the gain-compensated magnitude.
- Used to recover angle and amplitude from windowed sine samples for loop-back checking and phase measurement.
- Start/Done handshake in the same style as the window generator; one micro-rotation per clock.

Parameters:
- DATA_W, 16, width of signed X_i/Y_i and of unsigned Mag_o.
- PHASE_W, 16, width of signed Phase_o; full turn = 2^PHASE_W LSB, so half turn = 2^(PHASE_W-1).
- ITER, 16, number of micro-rotations; legal range 4..PHASE_W.

Ports:
- Clk_i  in  1  clock; all state changes on the rising edge.
- Rst_i  in  1  asynchronous, active-low reset.
- Start_i  in  1  request; sampled only when idle.
- X_i  in  DATA_W  signed X, two's complement; captured on the accepting edge.
- Y_i  in  DATA_W  signed Y; captured on the accepting edge.
- Busy_o  out  1  high while a conversion is in flight.
- Done_o  out  1  single-cycle pulse; Phase_o/Mag_o are valid from this cycle on.
- Phase_o  out  PHASE_W  signed phase, range [-2^(PHASE_W-1), 2^(PHASE_W-1)-1].
- Mag_o  out  DATA_W  unsigned magnitude, compensated for CORDIC gain.

Behaviour:
- Reset (Rst_i=0, asynchronous): state=IDLE; Busy_o=0, Done_o=0, Phase_o=0, Mag_o=0; iteration counter=0. Takes effect mid-conversion, discards the operation, and no Done_o follows.
- FSM states: IDLE, ITER, FIN.
- IDLE: if Start_i=1 on edge E0, capture inputs into the internal x, y, z registers, go to ITER, set Busy_o=1. Otherwise stay in IDLE.
- Internal width: x and y are DATA_W+2 bits signed; z is PHASE_W bits signed.
- Quadrant pre-rotation at capture:
  - X_i>=0: x=X, y=Y, z=0.
  - X_i<0 and Y_i>=0: x=-X, y=-Y, z=+half turn (wraps to -2^(PHASE_W-1)).
  - X_i<0 and Y_i<0: x=-X, y=-Y, z=-half turn.
- Zero input: if X_i=0 and Y_i=0, set a zero flag; the result is forced to Phase_o=0, Mag_o=0.
- ITER, step k = 0..ITER-1, one step per edge:
  - d = +1 if y<0, else -1.
  - x' = x - d*(y>>>k); y' = y + d*(x>>>k); z' = z - d*ATAN[k].
  - Shifts are arithmetic; all adds wrap within the register width. z wrap-around is intentional (modular phase).
  - After the step with k=ITER-1 (edge E0+ITER), go to FIN.
- FIN (edge E0+ITER+1):
  - Phase_o <= z.
  - Mag_o <= (x * KCOMP) >> 15, truncated. Result fits DATA_W unsigned, since the max is sqrt(2)*2^(DATA_W-1).
  - Done_o <= 1; Busy_o <= 0; state <= IDLE.
- Done_o is high for exactly the one cycle after edge E0+ITER+1, i.e. latency ITER+2 edges from Start sampling to Done visible.
- Outputs hold their value until the next FIN or reset.
- Start_i while Busy_o=1 is ignored; there is no queueing.
- Start_i=1 in the Done_o cycle is accepted, giving back-to-back throughput of one result per ITER+2 cycles. The new capture does not disturb Phase_o/Mag_o until its own FIN.
- Accuracy: |Phase error| <= ITER/4+2 LSB; |Mag error| <= 4 LSB for DATA_W=16, ITER=16.

Decomposition:
- Package cordic_pkg holds:
  - the ATAN table function: atan(2^-k) scaled to 2^PHASE_W per turn, rounded, k = 0..ITER-1, shared with the rotation-mode blocks.
  - KCOMP = 19898, i.e. round(0.607253*2^15).
  - HALF_TURN localparam.
  - the FSM state encoding.
- One sub-module, cordic_vec_step: a combinational micro-rotation with inputs x, y, z, shift k and ATAN[k], outputs x', y', z'. The top level holds the FSM, registers and pre/post processing.

Test Plan (DATA_W=16, PHASE_W=16, ITER=16):
- X=16384, Y=0 -> Done_o exactly 18 edges after Start; Phase_o=0 ±2; Mag_o=16384 ±4; Busy_o high for 17 cycles.
- X=0, Y=16384 -> Phase_o=16384 (quarter turn) ±4; Mag_o=16384 ±4. X=0, Y=-16384 -> Phase_o=-16384 ±4.
- X=-16384, Y=0 -> Phase_o=-32768 (half-turn wrap) ±4, or +32767 within wrap tolerance. X=-16384, Y=-16384 -> Phase_o=-24576 ±4, Mag_o=23170 ±4.
- X=Y=-32768 (extreme corner, no overflow) -> Phase_o=-24576 ±4, Mag_o=46341 ±4. X=Y=0 -> Phase_o=0, Mag_o=0.
- Pulse Start_i again 5 cycles into a conversion -> ignored: one Done_o only, outputs match the first operands. Then Start_i held high across the Done_o cycle -> second result 18 cycles after the first Done.
- Drive Rst_i=0 asynchronously mid-ITER -> Busy_o, Done_o, Phase_o, Mag_o read 0 immediately; no Done_o after release; the next Start converts correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain compensation, FSM encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Round(0.607253 * 2^15). This is the inverse of the accumulated CORDIC gain.
    localparam int KCOMP       = 19898;
    localparam int KCOMP_SHIFT = 15;

    // Half turn on a 32-bit phase scale. Narrower phases take the top bits.
    localparam logic [31:0] HALF_TURN = 32'h8000_0000;

    // atan(2^-k) on a scale of 2^32 per full turn.
    function automatic logic [31:0] atan_turn32(input int k);
        case (k)
            0:       return 32'h2000_0000;
            1:       return 32'h12E4_051E;
            2:       return 32'h09FB_385B;
            3:       return 32'h0511_11D4;
            4:       return 32'h028B_0D43;
            5:       return 32'h0145_D7E1;
            6:       return 32'h00A2_F61E;
            7:       return 32'h0051_7C55;
            8:       return 32'h0028_BE53;
            9:       return 32'h0014_5F2F;
            10:      return 32'h000A_2F98;
            11:      return 32'h0005_17CC;
            12:      return 32'h0002_8BE6;
            13:      return 32'h0001_45F3;
            14:      return 32'h0000_A2FA;
            15:      return 32'h0000_517D;
            16:      return 32'h0000_28BE;
            17:      return 32'h0000_145F;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // atan(2^-k) rounded to a scale of 2^phase_w per turn (phase_w <= 32).
    function automatic logic [31:0] atan_lsb(input int k, input int phase_w);
        logic [32:0] r;
        if (phase_w >= 32) begin
            return atan_turn32(k);
        end
        r = {1'b0, atan_turn32(k)} + (33'd1 << (31 - phase_w));
        r = r >> (32 - phase_w);
        return r[31:0];
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode micro-rotation: steers y toward zero and accumulates the angle.
// Latency: combinational.
// Backpressure: none.
module cordic_vec_step #(
    parameter int XY_W    = 18,
    parameter int PHASE_W = 16,
    parameter int SH_W    = 4
) (
    input  logic signed [XY_W-1:0]    x_cur,
    input  logic signed [XY_W-1:0]    y_cur,
    input  logic signed [PHASE_W-1:0] z_cur,
    input  logic [SH_W-1:0]           shift,
    input  logic [PHASE_W-1:0]        atan_k,
    output logic signed [XY_W-1:0]    x_nxt,
    output logic signed [XY_W-1:0]    y_nxt,
    output logic signed [PHASE_W-1:0] z_nxt
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;

    assign x_sh = x_cur >>> shift;
    assign y_sh = y_cur >>> shift;

    always_comb begin
        x_nxt = x_cur;
        y_nxt = y_cur;
        z_nxt = z_cur;
        if (y_cur[XY_W-1]) begin
            x_nxt = x_cur - y_sh;
            y_nxt = y_cur + x_sh;
            z_nxt = z_cur - atan_k;
        end else begin
            x_nxt = x_cur + y_sh;
            y_nxt = y_cur - x_sh;
            z_nxt = z_cur + atan_k;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (X, Y) -> atan2 phase and gain-compensated magnitude.
// Latency: ITER+2 edges from accepted Start_i to Done_o visible; one step per clock.
// Backpressure: Start_i is ignored while Busy_o is high; no queueing.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 16,
    parameter int ITER    = 16
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               Start_i,
    input  logic [DATA_W-1:0]  X_i,
    input  logic [DATA_W-1:0]  Y_i,
    output logic               Busy_o,
    output logic               Done_o,
    output logic [PHASE_W-1:0] Phase_o,
    output logic [DATA_W-1:0]  Mag_o
);

    localparam int IW    = DATA_W + 2;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int SH_W  = $clog2(PHASE_W);
    localparam logic [PHASE_W-1:0] HALF = HALF_TURN[31 -: PHASE_W];

    state_t state_q;
    state_t state_d;

    logic signed [IW-1:0]      x_q, y_q, x_nxt, y_nxt;
    logic signed [IW-1:0]      x_ext, y_ext;
    logic signed [PHASE_W-1:0] z_q, z_nxt;
    logic [CNT_W-1:0]          cnt_q;
    logic                      zero_q;
    logic                      capture, step_en, finish;
    logic [31:0]               atan_full;
    logic [PHASE_W-1:0]        atan_k;
    logic [IW+KCOMP_SHIFT-1:0] prod;
    logic [DATA_W-1:0]         mag_full;

    assign x_ext = {{2{X_i[DATA_W-1]}}, X_i};
    assign y_ext = {{2{Y_i[DATA_W-1]}}, Y_i};

    always_comb begin
        atan_full = atan_lsb(int'(cnt_q), PHASE_W);
    end
    assign atan_k = atan_full[PHASE_W-1:0];

    cordic_vec_step #(
        .XY_W    (IW),
        .PHASE_W (PHASE_W),
        .SH_W    (SH_W)
    ) u_step (
        .x_cur  (x_q),
        .y_cur  (y_q),
        .z_cur  (z_q),
        .shift  (SH_W'(cnt_q)),
        .atan_k (atan_k),
        .x_nxt  (x_nxt),
        .y_nxt  (y_nxt),
        .z_nxt  (z_nxt)
    );

    // x is non-negative after the right-half-plane pre-rotation, so an unsigned multiply is safe.
    assign prod     = {{KCOMP_SHIFT{1'b0}}, x_q} * (IW + KCOMP_SHIFT)'(KCOMP);
    assign mag_full = DATA_W'(prod >> KCOMP_SHIFT);

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start_i) state_d = ST_ITER;
            ST_ITER: if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        capture = (state_q == ST_IDLE) && Start_i;
        step_en = (state_q == ST_ITER);
        finish  = (state_q == ST_FIN);
        Busy_o  = (state_q != ST_IDLE);
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            Done_o  <= 1'b0;
            Phase_o <= '0;
            Mag_o   <= '0;
        end else begin
            Done_o <= finish;
            if (capture) begin
                cnt_q  <= '0;
                zero_q <= (X_i == '0) && (Y_i == '0);
                // Left half-plane: rotate by a half turn; +half and -half share one encoding.
                if (X_i[DATA_W-1]) begin
                    x_q <= -x_ext;
                    y_q <= -y_ext;
                    z_q <= HALF;
                end else begin
                    x_q <= x_ext;
                    y_q <= y_ext;
                    z_q <= '0;
                end
            end else if (step_en) begin
                x_q   <= x_nxt;
                y_q   <= y_nxt;
                z_q   <= z_nxt;
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                Phase_o <= zero_q ? '0 : z_q;
                Mag_o   <= zero_q ? '0 : mag_full;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring with a scoreboard of expected results.
module tb_cordic_vectoring;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] phase;
    logic [15:0] mag;

    typedef struct {
        string tag;
        int    phase;
        int    mag;
        int    ptol;
        int    mtol;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    cordic_vectoring #(.DATA_W(16), .PHASE_W(16), .ITER(16)) dut (
        .Clk_i   (clk),
        .Rst_i   (rst_n),
        .Start_i (start),
        .X_i     (x_in),
        .Y_i     (y_in),
        .Busy_o  (busy),
        .Done_o  (done),
        .Phase_o (phase),
        .Mag_o   (mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Phase compares modulo a full turn, so -32768 and +32767 are one LSB apart.
    task automatic check_tol(input string tag, input int obs, input int expv, input int tol, input bit modular);
        int d;
        logic signed [15:0] d16;
        if (modular) begin
            d16 = 16'(obs - expv);
            d = int'(d16);
        end else begin
            d = obs - expv;
        end
        if (d < 0) d = -d;
        total++;
        assert ((d <= tol) === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            done_seen++;
            check("done_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_tol({e.tag, "_phase"}, int'($signed(phase)), e.phase, e.ptol, 1'b1);
                check_tol({e.tag, "_mag"}, int'(mag), e.mag, e.mtol, 1'b0);
            end
        end
    end

    task automatic push(input string tag, input int p, input int m, input int pt, input int mt);
        exp_t e;
        e.tag = tag; e.phase = p; e.mag = m; e.ptol = pt; e.mtol = mt;
        sb.push_back(e);
    endtask

    task automatic run_one(input logic [15:0] x, input logic [15:0] y, input int p, input int m,
                           input int pt, input int mt, input string tag);
        int n;
        @(negedge clk);
        x_in = x; y_in = y; start = 1'b1;
        push(tag, p, m, pt, mt);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, int'(done), 1);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int gap;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_mag", int'(mag), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency, busy width and done pulse width
        x_in = 16'd16384; y_in = 16'd0; start = 1'b1;
        push("east", 0, 16384, 2, 4);
        lat = 0; busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency_edges", lat, 18);
        check("busy_cycles", busy_cnt, 17);
        @(posedge clk); #1;
        check("done_width", int'(done), 0);

        // Quadrants, wrap and extremes
        run_one(16'd0, 16'd16384, 16384, 16384, 4, 4, "north");
        run_one(16'd0, -16'sd16384, -16384, 16384, 4, 4, "south");
        run_one(-16'sd16384, 16'd0, -32768, 16384, 4, 4, "west");
        run_one(-16'sd16384, -16'sd16384, -24576, 23170, 4, 4, "southwest");
        run_one(16'h8000, 16'h8000, -24576, 46341, 4, 4, "corner");
        run_one(16'd0, 16'd0, 0, 0, 0, 0, "zero");
        run_one(16'd16384, 16'd16384, 8192, 23170, 4, 4, "northeast");

        // Start while busy is ignored
        @(negedge clk);
        d0 = done_seen;
        x_in = 16'd16384; y_in = 16'd16384; start = 1'b1;
        push("ignored_start", 8192, 23170, 4, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        x_in = -16'sd16384; y_in = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("single_done", done_seen - d0, 1);

        // Back-to-back with start held across the done cycle
        x_in = 16'd0; y_in = 16'd16384; start = 1'b1;
        push("b2b_first", 16384, 16384, 4, 4);
        @(posedge clk); #1;
        x_in = -16'sd16384; y_in = -16'sd16384;
        push("b2b_second", -24576, 23170, 4, 4);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("b2b_first_done", int'(done), 1);
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0;
                check("b2b_busy_after_accept", int'(busy), 1);
            end
            if (done) begin
                gap = i;
                break;
            end
        end
        check("b2b_gap", gap, 18);
        @(negedge clk);

        // Asynchronous reset mid-conversion
        x_in = 16'd16384; y_in = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_phase", int'(phase), 0);
        check("arst_mag", int'(mag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_seen;
        repeat (30) @(negedge clk);
        check("no_done_after_arst", done_seen - d0, 0);

        run_one(16'd16384, 16'd16384, 8192, 23170, 4, 4, "after_reset");
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
